// File: rtl/field_store.sv
// -----------------------------------------------------------------------------
// field_store
//
// Registered playfield store with automatic line clearing. A qualified commit
// loads a candidate field image. The stored field is then scanned bottom-up,
// one row per cycle. Every full row is removed by shifting all rows above it
// down by one, and the number of removed rows is reported. This block is the
// only holder of the settled field.
//
// Parameters
//   COLS  columns per row
//   ROWS  rows in the field (row 0 is the bottom row)
//   TW    width of the running total-lines counter
//   CW    derived: $clog2(ROWS+1), width of the per-commit line count
//
// Ports
//   clk            clock, rising edge
//   reset          asynchronous active-low reset
//   clear          synchronous wipe of the field; abandons any scan, no done
//   commit_valid   candidate field present on field_in
//   commit_ok      collision check passed (qualifies commit_valid)
//   field_in       candidate field, row r at bits [r*COLS +: COLS]
//   commit_ready   high exactly while idle (commits accepted only then)
//   field_out      registered stored field
//   busy           high while scanning or finishing
//   done           one-cycle pulse when the scan of a commit completes
//   lines_cleared  rows removed by the last commit, held until the next one
//   total_lines    accumulated cleared rows, saturating at 2^TW-1
// -----------------------------------------------------------------------------
module field_store #(
    parameter int COLS = 10,
    parameter int ROWS = 40,
    parameter int TW   = 16,
    localparam int CW  = $clog2(ROWS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 commit_valid,
    input  logic                 commit_ok,
    input  logic [COLS*ROWS-1:0] field_in,
    output logic                 commit_ready,
    output logic [COLS*ROWS-1:0] field_out,
    output logic                 busy,
    output logic                 done,
    output logic [CW-1:0]        lines_cleared,
    output logic [TW-1:0]        total_lines
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int FW = COLS * ROWS;
    // Sum width wide enough that acc + inc can never wrap before the clamp.
    localparam int SW = ((TW > CW) ? TW : CW) + 1;

    localparam logic [CW-1:0] IDX_TOP   = CW'(ROWS - 1);
    localparam logic [TW-1:0] TOTAL_MAX = {TW{1'b1}};

    logic [1:0]      state;
    logic [CW-1:0]   idx;
    logic [ROWS-1:0] row_full;
    logic            cur_full;
    logic [FW-1:0]   field_shift;

    // Saturating accumulate of the per-commit line count into the total.
    function automatic logic [TW-1:0] sat_add(input logic [TW-1:0] acc,
                                              input logic [CW-1:0] inc);
        logic [SW-1:0] sum;
        sum = SW'(acc) + SW'(inc);
        if (sum > SW'(TOTAL_MAX)) begin
            return TOTAL_MAX;
        end
        return sum[TW-1:0];
    endfunction

    always_comb begin
        row_full = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_full[r] = &field_out[r*COLS +: COLS];
        end
    end

    // Select the fullness of the row currently under the scan index.
    always_comb begin
        cur_full = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (idx == CW'(r)) begin
                cur_full = row_full[r];
            end
        end
    end

    // Field with row idx removed: rows at or above idx take the row above,
    // the top row is refilled with zeros. Rows below idx are untouched.
    always_comb begin
        field_shift = field_out;
        for (int r = 0; r < ROWS - 1; r++) begin
            if (CW'(r) >= idx) begin
                field_shift[r*COLS +: COLS] = field_out[(r+1)*COLS +: COLS];
            end
        end
        field_shift[(ROWS-1)*COLS +: COLS] = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            idx           <= '0;
            field_out     <= '0;
            lines_cleared <= '0;
            total_lines   <= '0;
        end else if (clear) begin
            // total_lines deliberately survives a wipe.
            state         <= S_IDLE;
            idx           <= '0;
            field_out     <= '0;
            lines_cleared <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (commit_valid && commit_ok) begin
                        field_out     <= field_in;
                        idx           <= '0;
                        lines_cleared <= '0;
                        state         <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (cur_full) begin
                        // idx stays put: the row shifted into it is checked next.
                        field_out     <= field_shift;
                        lines_cleared <= lines_cleared + CW'(1);
                    end else if (idx == IDX_TOP) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx + CW'(1);
                    end
                end
                S_DONE: begin
                    total_lines <= sat_add(total_lines, lines_cleared);
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign commit_ready = (state == S_IDLE);
    assign busy         = (state == S_SCAN) || (state == S_DONE);
    assign done         = (state == S_DONE);

endmodule

// File: doc/field_store.md
# field_store

Registered playfield store with automatic line clearing; the parametrised successor to the single-latch background field. It loads a checked field image on a qualified commit, then scans it row by row, removes every full row by shifting the rows above it down, and reports how many lines were cleared. It sits between the collision/merge check and the renderer and score logic, and it is the only holder of the settled field.

## Interface
Parameters:
- `COLS`, 10: columns per row.
- `ROWS`, 40: rows in the field. Row 0 is the bottom row.
- `TW`, 16: width of the running total-lines counter.

Ports:
- `clk` input 1: clock. All state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous field wipe. Has priority over everything except `reset`.
- `commit_valid` input 1: a candidate field is present on `field_in`.
- `commit_ok` input 1: the collision check passed. Meaningful only together with `commit_valid`.
- `field_in` input COLS*ROWS: candidate field. Row r occupies bits [r*COLS +: COLS].
- `commit_ready` output 1: high exactly when in IDLE.
- `field_out` output COLS*ROWS: the registered stored field.
- `busy` output 1: high in SCAN and DONE.
- `done` output 1: one-cycle pulse in the DONE state.
- `lines_cleared` output CW: rows removed by the last commit, with CW = $clog2(ROWS+1). Holds its value until the next accepted commit.
- `total_lines` output TW: accumulated cleared rows. Saturates at 2^TW-1.

## Operation
- States: IDLE, SCAN, DONE. A row index `idx` (CW bits) is used only during SCAN.
- **IDLE**
  - `commit_valid && commit_ok`: load `field_out <= field_in`, set `idx <= 0` and `lines_cleared <= 0`, go to SCAN.
  - `commit_valid && !commit_ok`: ignored. The field is held.
- **SCAN**, one row evaluated per cycle:
  - Row `idx` full (all COLS bits 1): rows idx..ROWS-2 take the contents of the row above, row ROWS-1 becomes 0, and `lines_cleared` increments. `idx` does not change, so the same row is re-examined next cycle.
  - Row `idx` not full and `idx < ROWS-1`: `idx` increments.
  - Row `idx` not full and `idx == ROWS-1`: go to DONE.
- **DONE**
  - Assert `done`.
  - Add `lines_cleared` to `total_lines`, saturating.
  - Go to IDLE.
- **Commits outside IDLE** are dropped silently, whatever `commit_ok` is. The producer must honour `commit_ready`.
- **`clear`**, in any state:
  - `field_out <= 0`, `lines_cleared <= 0`, go to IDLE.
  - `total_lines` is left unchanged.
  - No `done` pulse is produced. A scan in progress is abandoned.
- **Full top row:** after it is shifted out, row ROWS-1 holds 0, so the scan always terminates.
- **Worst case:** every row full. This takes ROWS shift cycles plus ROWS-1 advance cycles, and the final compare sees an empty row.

## Timing
- Reset values:
  - `field_out` = 0, `lines_cleared` = 0, `total_lines` = 0.
  - State is IDLE, so `commit_ready` = 1.
  - `busy` = 0, `done` = 0.
- All outputs are registered or decoded from registered state. No combinational path runs from inputs to outputs.
- Commit accepted at edge N:
  - `field_out` equals `field_in` from N+1.
  - `busy` = 1 and `commit_ready` = 0 from N+1.
- With k rows cleared:
  - SCAN lasts ROWS+k cycles.
  - `done` is high during cycle N+ROWS+k+1.
  - IDLE is re-entered at N+ROWS+k+2.
- `field_out` reflects each shift in the cycle after the shift decision. It is final when `done` is high.
- `lines_cleared` is valid while `done` is high and stays stable until the next accepted commit or `clear`.
- `total_lines` updates on the edge that leaves DONE.
- `reset` asserted mid-scan forces all reset values immediately, without waiting for a clock edge.
- `clear` and `commit_valid && commit_ok` in the same IDLE cycle: `clear` wins and the commit is lost.

## Test plan
All scenarios use COLS=4 and ROWS=4.
- **Reset.** Drive `reset`=0 with no clock, then release it. Required: `field_out`=0x0000, `commit_ready`=1, `busy`=0, `total_lines`=0.
- **Rejected commit.** In IDLE drive `field_in`=0x1234, `commit_valid`=1, `commit_ok`=0. Required: `field_out` stays 0x0000 and `busy` stays 0.
- **No clear.** Commit 0x0137 with `commit_ok`=1 at edge N. Required:
  - `field_out`=0x0137 from N+1.
  - `done` high at N+5 with `lines_cleared`=0.
  - IDLE at N+6.
- **Two non-adjacent full rows.** Commit 0x5F3F (rows bottom-up: F,3,F,5). Required:
  - `field_out`=0x0053 when `done` is high.
  - `lines_cleared`=2.
  - `done` at N+7.
  - `total_lines`=2 afterwards.
- **All rows full.** Commit 0xFFFF. Required:
  - `field_out`=0x0000.
  - `lines_cleared`=4.
  - `done` at N+9.
  - A commit offered mid-scan is ignored, and `field_out` is still 0x0000 at `done`.
- **Abort and saturation.**
  - Assert `clear` during SCAN. Required: `field_out`=0, IDLE next cycle, no `done`, `total_lines` unchanged.
  - With TW=2 and `total_lines`=3, clear one more line. Required: `total_lines` stays 3.
